// File: rtl/ili9341_8080_rx_if.sv
// ili9341_8080_rx_if: 8080-I write bus towards the panel plus framebuffer writes and status back.
interface ili9341_8080_rx_if #(parameter int ADDR_W = 17);
   logic [7:0]        tftParallelPort;
   logic              tftChipSelect;
   logic              tftWriteEnable;
   logic              tftDataCmd;
   logic              tftReset;
   logic [ADDR_W-1:0] pixelAddr;
   logic [15:0]       pixelData;
   logic              pixelWe;
   logic              dispOn;
   logic              sleepOut;
   logic              windowErr;
   modport master(output tftParallelPort, tftChipSelect, tftWriteEnable, tftDataCmd, tftReset,
                  input pixelAddr, pixelData, pixelWe, dispOn, sleepOut, windowErr);
   modport slave(input tftParallelPort, tftChipSelect, tftWriteEnable, tftDataCmd, tftReset,
                 output pixelAddr, pixelData, pixelWe, dispOn, sleepOut, windowErr);
endinterface

// File: rtl/ili9341_8080_rx.sv
// ili9341_8080_rx: ILI9341 8080-I write receiver decoding CASET/PASET/RAMWR into RGB565 pixel writes.
// Define ILI9341_RX_STATS_EN to add saturating cmdCount/pixelCount outputs.
module ili9341_8080_rx #(
   parameter int WIDTH  = 240,
   parameter int HEIGHT = 320,
   parameter int ADDR_W = 17
) (
   input logic clk,
   input logic reset,
   ili9341_8080_rx_if.slave bus
`ifdef ILI9341_RX_STATS_EN
   ,
   output logic [15:0] cmdCount,
   output logic [23:0] pixelCount
`endif
);
   typedef enum logic [2:0] {CMD, CASET_P, PASET_P, RAMWR, IGNORE} state_t;
   localparam logic [15:0] W16 = 16'(WIDTH);
   localparam logic [15:0] H16 = 16'(HEIGHT);
   localparam logic [ADDR_W-1:0] WA = ADDR_W'(WIDTH);
   logic [1:0] cs_s, wr_s, dc_s, rs_s;
   logic [7:0] d1, d2, b1, b2;
   logic wr_q, ev1, ev2, dc1, dc2, rst_any, sw_rst, evt;
   state_t state, state_n;
   logic [1:0] idx, idx_n;
   logic [23:0] par, par_n;
   logic [15:0] col_start, col_end, page_start, page_end, col, page;
   logic [15:0] col_start_n, col_end_n, page_start_n, page_end_n, col_n, page_n;
   logic [15:0] s16, e16;
   logic lsb, lsb_n, we_n, on_n, slp_n, err_n;
   logic [7:0] msb, msb_n;
   logic [ADDR_W-1:0] addr_n;
   logic [15:0] data_n;
   assign rst_any = reset | ~rs_s[1];
   assign evt = wr_s[1] & ~wr_q & ~cs_s[1];
   always_ff @(posedge clk) begin
      if (reset) begin
         cs_s <= 2'b11;
         wr_s <= 2'b11;
         rs_s <= 2'b11;
         dc_s <= 2'b00;
         d1 <= 8'd0;
         d2 <= 8'd0;
         wr_q <= 1'b1;
      end else begin
         cs_s <= {cs_s[0], bus.tftChipSelect};
         wr_s <= {wr_s[0], bus.tftWriteEnable};
         rs_s <= {rs_s[0], bus.tftReset};
         dc_s <= {dc_s[0], bus.tftDataCmd};
         d1 <= bus.tftParallelPort;
         d2 <= d1;
         wr_q <= wr_s[1];
      end
   end
   // Two event stages place the pixel strobe four edges after WRX is first seen high
   always_ff @(posedge clk) begin
      if (rst_any) begin
         {ev1, ev2, dc1, dc2} <= 4'd0;
         b1 <= 8'd0;
         b2 <= 8'd0;
      end else begin
         ev1 <= evt;
         dc1 <= dc_s[1];
         b1 <= d2;
         ev2 <= ev1;
         dc2 <= dc1;
         b2 <= b1;
      end
   end
   assign s16 = par[23:8];
   assign e16 = {par[7:0], b2};
   always_comb begin
      state_n = state;
      idx_n = idx;
      par_n = par;
      col_start_n = col_start;
      col_end_n = col_end;
      page_start_n = page_start;
      page_end_n = page_end;
      col_n = col;
      page_n = page;
      lsb_n = lsb;
      msb_n = msb;
      addr_n = bus.pixelAddr;
      data_n = bus.pixelData;
      we_n = 1'b0;
      on_n = bus.dispOn;
      slp_n = bus.sleepOut;
      err_n = bus.windowErr;
      sw_rst = 1'b0;
      if (ev2 && !dc2) begin
         idx_n = 2'd0;
         lsb_n = 1'b0;
         state_n = CMD;
         case (b2)
            8'h2A: state_n = CASET_P;
            8'h2B: state_n = PASET_P;
            8'h2C: begin
               state_n = RAMWR;
               col_n = col_start;
               page_n = page_start;
            end
            8'h01: sw_rst = 1'b1;
            8'h11: slp_n = 1'b1;
            8'h29: on_n = 1'b1;
            8'h28: on_n = 1'b0;
            default: state_n = IGNORE;
         endcase
      end else if (ev2 && (state == CASET_P || state == PASET_P)) begin
         par_n = {par[15:0], b2};
         idx_n = idx + 2'd1;
         if (idx == 2'd3) begin
            state_n = CMD;
            if (state == CASET_P && s16 <= e16 && e16 < W16) begin
               col_start_n = s16;
               col_end_n = e16;
            end else if (state == PASET_P && s16 <= e16 && e16 < H16) begin
               page_start_n = s16;
               page_end_n = e16;
            end else
               err_n = 1'b1;
         end
      end else if (ev2 && state == RAMWR) begin
         lsb_n = ~lsb;
         msb_n = b2;
         if (lsb) begin
            we_n = 1'b1;
            data_n = {msb, b2};
            addr_n = ADDR_W'(page) * WA + ADDR_W'(col);
            col_n = col < col_end ? col + 16'd1 : col_start;
            page_n = col < col_end ? page : page == page_end ? page_start : page + 16'd1;
         end
      end
   end
   always_ff @(posedge clk) begin
      if (rst_any || sw_rst) begin
         state <= CMD;
         idx <= 2'd0;
         par <= 24'd0;
         col_start <= 16'd0;
         col_end <= W16 - 16'd1;
         page_start <= 16'd0;
         page_end <= H16 - 16'd1;
         col <= 16'd0;
         page <= 16'd0;
         lsb <= 1'b0;
         msb <= 8'd0;
         bus.pixelAddr <= '0;
         bus.pixelData <= 16'd0;
         bus.pixelWe <= 1'b0;
         bus.dispOn <= 1'b0;
         bus.sleepOut <= 1'b0;
         bus.windowErr <= 1'b0;
      end else begin
         state <= state_n;
         idx <= idx_n;
         par <= par_n;
         col_start <= col_start_n;
         col_end <= col_end_n;
         page_start <= page_start_n;
         page_end <= page_end_n;
         col <= col_n;
         page <= page_n;
         lsb <= lsb_n;
         msb <= msb_n;
         bus.pixelAddr <= addr_n;
         bus.pixelData <= data_n;
         bus.pixelWe <= we_n;
         bus.dispOn <= on_n;
         bus.sleepOut <= slp_n;
         bus.windowErr <= err_n;
      end
   end
`ifdef ILI9341_RX_STATS_EN
   always_ff @(posedge clk) begin
      if (rst_any || sw_rst) begin
         cmdCount <= 16'd0;
         pixelCount <= 24'd0;
      end else begin
         if (ev2 && !dc2 && !(&cmdCount)) cmdCount <= cmdCount + 16'd1;
         if (we_n && !(&pixelCount)) pixelCount <= pixelCount + 24'd1;
      end
   end
`endif
endmodule

// File: tb/tb_ili9341_8080_rx.sv
// tb_ili9341_8080_rx: drives 8080-I byte writes and scoreboards the resulting pixel writes and flags.
module tb_ili9341_8080_rx;
   logic clk = 1'b0;
   logic reset = 1'b1;
   always #5 clk = ~clk;
   ili9341_8080_rx_if #(.ADDR_W(17)) bus();
`ifdef ILI9341_RX_STATS_EN
   logic [15:0] cmd_count;
   logic [23:0] pixel_count;
`endif
   ili9341_8080_rx #(.WIDTH(240), .HEIGHT(320), .ADDR_W(17)) dut (
      .clk(clk),
      .reset(reset),
      .bus(bus.slave)
`ifdef ILI9341_RX_STATS_EN
      ,
      .cmdCount(cmd_count),
      .pixelCount(pixel_count)
`endif
   );
   int checks = 0;
   int errors = 0;
   logic [32:0] q[$];
   logic [32:0] e;
   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %0h expected %0h", tag, got, exp);
      end
   endtask
   always @(negedge clk) begin
      if (bus.pixelWe === 1'b1) begin
         if (q.size() == 0) chk("spurious_we", 32'(bus.pixelWe), 32'd0);
         else begin
            e = q.pop_front();
            chk("pix_addr", 32'(bus.pixelAddr), 32'(e[32:16]));
            chk("pix_data", 32'(bus.pixelData), 32'(e[15:0]));
         end
      end
   end
   task automatic bus_wr(input logic dc, input logic [7:0] b);
      @(negedge clk);
      bus.tftDataCmd = dc;
      bus.tftParallelPort = b;
      bus.tftWriteEnable = 1'b0;
      repeat (4) @(negedge clk);
      bus.tftWriteEnable = 1'b1;
      repeat (6) @(negedge clk);
   endtask
   task automatic cmd(input logic [7:0] b);
      bus_wr(1'b0, b);
   endtask
   task automatic dat(input logic [7:0] b);
      bus_wr(1'b1, b);
   endtask
   task automatic win(input logic [7:0] c, input logic [15:0] s, input logic [15:0] en);
      cmd(c);
      dat(s[15:8]);
      dat(s[7:0]);
      dat(en[15:8]);
      dat(en[7:0]);
   endtask
   task automatic pix(input logic [16:0] a, input logic [15:0] d);
      dat(d[15:8]);
      q.push_back({a, d});
      dat(d[7:0]);
   endtask
   // strobe must appear exactly on the 4th edge after the first edge that sees WRX high
   task automatic pix_lat(input logic [16:0] a, input logic [15:0] d);
      int first, width;
      dat(d[15:8]);
      q.push_back({a, d});
      @(negedge clk);
      bus.tftDataCmd = 1'b1;
      bus.tftParallelPort = d[7:0];
      bus.tftWriteEnable = 1'b0;
      repeat (4) @(negedge clk);
      bus.tftWriteEnable = 1'b1;
      first = 0;
      width = 0;
      for (int k = 1; k <= 8; k++) begin
         @(posedge clk);
         #1;
         if (bus.pixelWe === 1'b1) begin
            width++;
            if (first == 0) first = k;
         end
      end
      chk("we_latency", 32'(first), 32'd5);
      chk("we_width", 32'(width), 32'd1);
      repeat (2) @(negedge clk);
   endtask
   task automatic chk_idle(input string tag);
      chk({tag, "_dispOn"}, 32'(bus.dispOn), 32'd0);
      chk({tag, "_sleepOut"}, 32'(bus.sleepOut), 32'd0);
      chk({tag, "_windowErr"}, 32'(bus.windowErr), 32'd0);
      chk({tag, "_pixelWe"}, 32'(bus.pixelWe), 32'd0);
      chk({tag, "_pixelAddr"}, 32'(bus.pixelAddr), 32'd0);
      chk({tag, "_pixelData"}, 32'(bus.pixelData), 32'd0);
   endtask
   initial begin
      #600000;
      $display("FAIL watchdog timeout");
      $fatal(1, "watchdog");
   end
   initial begin
      logic [16:0] a3 [5];
      a3[0] = 17'd1210;
      a3[1] = 17'd1211;
      a3[2] = 17'd1450;
      a3[3] = 17'd1451;
      a3[4] = 17'd1210;
      bus.tftChipSelect = 1'b1;
      bus.tftWriteEnable = 1'b1;
      bus.tftDataCmd = 1'b1;
      bus.tftParallelPort = 8'h00;
      bus.tftReset = 1'b1;
      repeat (5) @(negedge clk);
      reset = 1'b0;
      repeat (5) @(negedge clk);
      chk_idle("reset");
      bus.tftChipSelect = 1'b0;
      cmd(8'h11);
      chk("slpout_sleepOut", 32'(bus.sleepOut), 32'd1);
      chk("slpout_dispOn", 32'(bus.dispOn), 32'd0);
      cmd(8'h29);
      chk("dispon", 32'(bus.dispOn), 32'd1);
      win(8'h2A, 16'h0000, 16'h00EF);
      win(8'h2B, 16'h0000, 16'h013F);
      cmd(8'h2C);
      pix_lat(17'd0, 16'hF800);
      pix(17'd1, 16'h07E0);
      chk("full_win_err", 32'(bus.windowErr), 32'd0);
      win(8'h2A, 16'h000A, 16'h000B);
      win(8'h2B, 16'h0005, 16'h0006);
      cmd(8'h2C);
      for (int i = 0; i < 5; i++) pix(a3[i], 16'h1000 + 16'(i));
      chk("hold_addr", 32'(bus.pixelAddr), 32'd1210);
      win(8'h2A, 16'h0010, 16'h0005);
      chk("bad_caset_err", 32'(bus.windowErr), 32'd1);
      cmd(8'h2A);
      dat(8'h00);
      dat(8'h00);
      cmd(8'h2C);
      pix(17'd1210, 16'hABCD);
      cmd(8'h28);
      chk("dispoff", 32'(bus.dispOn), 32'd0);
      cmd(8'h29);
      cmd(8'h2C);
      dat(8'h12);
      bus.tftChipSelect = 1'b1;
      for (int i = 0; i < 4; i++) dat(8'h00);
      cmd(8'h28);
      bus.tftChipSelect = 1'b0;
      chk("cs_high_dispOn", 32'(bus.dispOn), 32'd1);
      q.push_back({17'd1210, 16'h1234});
      dat(8'h34);
      cmd(8'h2C);
      pix(17'd1210, 16'h5A5A);
      cmd(8'h2C);
      dat(8'h55);
      cmd(8'h00);
      dat(8'h66);
      dat(8'h77);
      cmd(8'h2C);
      pix(17'd1210, 16'h9ABC);
      cmd(8'h2C);
      dat(8'hAA);
      @(negedge clk);
      bus.tftReset = 1'b0;
      repeat (10) @(negedge clk);
      bus.tftReset = 1'b1;
      repeat (5) @(negedge clk);
      chk_idle("resx");
      cmd(8'h2C);
      pix(17'd0, 16'hBEEF);
      pix(17'd1, 16'hCAFE);
      win(8'h2A, 16'h00EE, 16'h00EF);
      win(8'h2B, 16'h013F, 16'h013F);
      chk("edge_win_err", 32'(bus.windowErr), 32'd0);
      cmd(8'h2C);
      pix(17'd76798, 16'h0001);
      pix(17'd76799, 16'h0002);
      pix(17'd76798, 16'h0003);
      win(8'h2A, 16'h0000, 16'h00F0);
      chk("caset_w_err", 32'(bus.windowErr), 32'd1);
      cmd(8'h2C);
      pix(17'd76798, 16'h0004);
      cmd(8'h11);
      cmd(8'h29);
      cmd(8'h01);
      chk_idle("swreset");
      cmd(8'h2C);
      pix(17'd0, 16'h0F0F);
      repeat (20) @(negedge clk);
      chk("queue_empty", 32'(q.size()), 32'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
